// File: rtl/zeroriscy_defines.sv
// Shared definitions for the instruction encoder slice.
// Contents: RV32 opcodes, including the custom BNN opcode.
//           The command class enum.
//           The fixed SYSTEM words and the funct7 selectors.
//           encode_cmd(), which turns one command into an instruction word
//           plus flags (illegal, LI needs a second ADDI).
package zeroriscy_defines;

   localparam logic [6:0] OPCODE_LUI    = 7'h37;
   localparam logic [6:0] OPCODE_AUIPC  = 7'h17;
   localparam logic [6:0] OPCODE_JAL    = 7'h6f;
   localparam logic [6:0] OPCODE_JALR   = 7'h67;
   localparam logic [6:0] OPCODE_BRANCH = 7'h63;
   localparam logic [6:0] OPCODE_OPIMM  = 7'h13;
   localparam logic [6:0] OPCODE_OP     = 7'h33;
   localparam logic [6:0] OPCODE_SYSTEM = 7'h73;
   localparam logic [6:0] OPCODE_BNN    = 7'h0b;

   localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
   localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   localparam logic [31:0] SYS_ECALL  = 32'h0000_0073;
   localparam logic [31:0] SYS_EBREAK = 32'h0010_0073;
   localparam logic [31:0] SYS_MRET   = 32'h3020_0073;
   localparam logic [31:0] SYS_WFI    = 32'h1050_0073;

   typedef enum logic [3:0] {
      CMD_LUI    = 4'd0,
      CMD_AUIPC  = 4'd1,
      CMD_JAL    = 4'd2,
      CMD_JALR   = 4'd3,
      CMD_BRANCH = 4'd4,
      CMD_OPIMM  = 4'd5,
      CMD_OP     = 4'd6,
      CMD_MULDIV = 4'd7,
      CMD_CSR    = 4'd8,
      CMD_SYS    = 4'd9,
      CMD_BNN    = 4'd10,
      CMD_LI     = 4'd11
   } cmd_class_e;

   typedef struct packed {
      logic        illegal;
      logic        need_lo;
      logic [31:0] word;
   } enc_result_t;

   // Encode one command. For LI this yields the first word only (ADDI or LUI);
   // need_lo flags that an ADDI rd,rd,imm[11:0] must follow.
   function automatic enc_result_t encode_cmd(
      input logic [3:0]  cls,
      input logic [2:0]  f3,
      input logic        alt,
      input logic [4:0]  rd,
      input logic [4:0]  rs1,
      input logic [4:0]  rs2,
      input logic [31:0] imm
   );
      enc_result_t res;
      logic        bad;
      logic        alt_ok;
      logic [6:0]  f7_sel;
      logic [31:0] li_hi;
      logic [11:0] opimm_field;

      f7_sel = alt ? FUNCT7_ALT : FUNCT7_BASE;
      // LUI part rounds up, so the sign-extended ADDI low part lands on imm
      li_hi  = imm + 32'h0000_0800;
      // alt (funct7=0100000) only exists for SUB/SRA and SRAI
      alt_ok = ((cls == CMD_OP) && ((f3 == 3'd0) || (f3 == 3'd5))) ||
               ((cls == CMD_OPIMM) && (f3 == 3'd5));
      bad    = alt && !alt_ok;
      // shifts carry shamt in imm[4:0] and funct7 in place of imm[11:5]
      opimm_field = ((f3 == 3'd1) || (f3 == 3'd5)) ? {f7_sel, imm[4:0]} : imm[11:0];

      res.need_lo = 1'b0;
      res.word    = 32'h0000_0000;
      case (cls)
         CMD_LUI:    res.word = {imm[31:12], rd, OPCODE_LUI};
         CMD_AUIPC:  res.word = {imm[31:12], rd, OPCODE_AUIPC};
         CMD_JAL:    res.word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPCODE_JAL};
         CMD_JALR: begin
            res.word = {imm[11:0], rs1, 3'b000, rd, OPCODE_JALR};
            bad      = bad || (f3 != 3'd0);
         end
         CMD_BRANCH: begin
            res.word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPCODE_BRANCH};
            bad      = bad || (f3 == 3'd3);
         end
         CMD_OPIMM:  res.word = {opimm_field, rs1, f3, rd, OPCODE_OPIMM};
         CMD_OP:     res.word = {f7_sel, rs2, rs1, f3, rd, OPCODE_OP};
         CMD_MULDIV: res.word = {FUNCT7_MULDIV, rs2, rs1, f3, rd, OPCODE_OP};
         CMD_CSR: begin
            res.word = {imm[11:0], rs1, f3, rd, OPCODE_SYSTEM};
            bad      = bad || (f3 == 3'd0) || (f3 == 3'd4);
         end
         CMD_SYS: begin
            case (f3[1:0])
               2'd0:    res.word = SYS_ECALL;
               2'd1:    res.word = SYS_EBREAK;
               2'd2:    res.word = SYS_MRET;
               2'd3:    res.word = SYS_WFI;
               default: res.word = SYS_ECALL;
            endcase
            bad = bad || f3[2];
         end
         CMD_BNN:    res.word = {imm[6:0], rs2, rs1, f3, rd, OPCODE_BNN};
         CMD_LI: begin
            if (imm[31:11] == {21{imm[11]}}) begin
               res.word = {imm[11:0], 5'd0, 3'b000, rd, OPCODE_OPIMM};
            end else begin
               res.word    = {li_hi[31:12], rd, OPCODE_LUI};
               res.need_lo = (imm[11:0] != 12'd0);
            end
         end
         default:    bad = 1'b1;
      endcase

      res.illegal = bad;
      if (bad) begin
         res.word    = 32'h0000_0000;
         res.need_lo = 1'b0;
      end else begin
         res.word    = res.word;
      end
      return res;
   endfunction

endpackage

// File: rtl/zeroriscy_instr_fifo.sv
// Output FIFO for encoded instruction words.
// Ports: clk, rst_n  clock and asynchronous active-low reset.
//        flush_i     synchronous clear; it wins over push and pop.
//        push_i, data_i
//                    write one word (ignored when full).
//        pop_i       drop the head word (ignored when empty).
//        data_o, valid_o
//                    head word, forced to 0 when empty.
//        count_o, full_o
//                    occupancy and the full flag.
module zeroriscy_instr_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [31:0]              data_i,
   input  logic                     pop_i,
   output logic [31:0]              data_o,
   output logic                     valid_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

   logic [31:0]   mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;
   logic          push_ok_s;
   logic          pop_ok_s;

   assign full_o    = (count_r == DEPTH_C);
   assign valid_o   = (count_r != {(AW+1){1'b0}});
   assign push_ok_s = push_i && !full_o && !flush_i;
   assign pop_ok_s  = pop_i && valid_o && !flush_i;
   assign data_o    = valid_o ? mem_r[rd_ptr_r] : 32'h0000_0000;
   assign count_o   = count_r;

   // Storage, pointers (wrap naturally at power-of-two depth) and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 32'h0000_0000;
         end
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else if (flush_i) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= data_i;
            wr_ptr_r        <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         end
         count_r <= count_r + {{AW{1'b0}}, push_ok_s} - {{AW{1'b0}}, pop_ok_s};
      end
   end

endmodule

// File: rtl/zeroriscy_instr_encoder.sv
// Command-driven RV32IM/Xbnn instruction encoder feeding an injection FIFO.
// Ports: clk, rst_n  clock and asynchronous active-low reset.
//        flush_i     clears the FIFO and abandons any LI in flight.
//        cmd_*       field-level command over a valid/ready handshake.
//                    cmd_ready_o comes from registers; of the inputs, only
//                    flush_i masks it combinationally.
//        instr_*     FIFO head word with a valid/ready pop.
//        err_o       one-cycle pulse one cycle after an illegal command is
//                    consumed.
//        count_o     FIFO occupancy.
module zeroriscy_instr_encoder
   import zeroriscy_defines::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush_i,
   input  logic                          cmd_valid_i,
   output logic                          cmd_ready_o,
   input  logic [3:0]                    cmd_class_i,
   input  logic [2:0]                    cmd_funct3_i,
   input  logic                          cmd_alt_i,
   input  logic [4:0]                    cmd_rd_i,
   input  logic [4:0]                    cmd_rs1_i,
   input  logic [4:0]                    cmd_rs2_i,
   input  logic [31:0]                   cmd_imm_i,
   output logic                          instr_valid_o,
   output logic [31:0]                   instr_o,
   input  logic                          instr_ready_i,
   output logic                          err_o,
   output logic [$clog2(FIFO_DEPTH):0]   count_o
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = FIFO_DEPTH[CW-1:0];

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_LI_LO = 1'b1
   } enc_state_e;

   enc_state_e  state_r, state_s;
   logic [4:0]  li_rd_r, li_rd_s;
   logic [11:0] li_lo_r, li_lo_s;
   logic        ready_r;
   logic        err_r, err_s;
   logic        accept_s;
   logic        push_s;
   logic [31:0] push_word_s;
   logic        pop_s;
   logic        full_s;
   logic [CW-1:0] count_s;
   logic [CW-1:0] count_nxt_s;
   enc_result_t enc_s;

   assign cmd_ready_o = ready_r && !flush_i;
   assign accept_s    = cmd_valid_i && cmd_ready_o;
   assign pop_s       = instr_valid_o && instr_ready_i;
   assign err_o       = err_r;
   assign count_o     = count_s;
   assign enc_s       = encode_cmd(cmd_class_i, cmd_funct3_i, cmd_alt_i, cmd_rd_i,
                                   cmd_rs1_i, cmd_rs2_i, cmd_imm_i);

   // Encoder FSM next-state, FIFO push selection and illegal-command detection
   always_comb begin
      state_s     = state_r;
      li_rd_s     = li_rd_r;
      li_lo_s     = li_lo_r;
      push_s      = 1'b0;
      push_word_s = 32'h0000_0000;
      err_s       = 1'b0;
      if (flush_i) begin
         state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  if (enc_s.illegal) begin
                     err_s = 1'b1;
                  end else begin
                     push_s      = 1'b1;
                     push_word_s = enc_s.word;
                     if (enc_s.need_lo) begin
                        state_s = ST_LI_LO;
                        li_rd_s = cmd_rd_i;
                        li_lo_s = cmd_imm_i[11:0];
                     end else begin
                        state_s = ST_IDLE;
                     end
                  end
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_LI_LO: begin
               // full is taken from the registered count, a same-cycle pop does not help
               if (!full_s) begin
                  push_s      = 1'b1;
                  push_word_s = {li_lo_r, li_rd_r, 3'b000, li_rd_r, OPCODE_OPIMM};
                  state_s     = ST_IDLE;
               end else begin
                  state_s = ST_LI_LO;
               end
            end
            default: state_s = ST_IDLE;
         endcase
      end
   end

   // Occupancy after this edge; feeds the registered ready
   always_comb begin
      if (flush_i) begin
         count_nxt_s = {CW{1'b0}};
      end else begin
         count_nxt_s = count_s + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
      end
   end

   // FSM state, LI latch, registered ready and error pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         li_rd_r <= 5'd0;
         li_lo_r <= 12'd0;
         ready_r <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         li_rd_r <= li_rd_s;
         li_lo_r <= li_lo_s;
         ready_r <= (state_s == ST_IDLE) && (count_nxt_s != DEPTH_C);
         err_r   <= err_s;
      end
   end

   zeroriscy_instr_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush_i),
      .push_i  (push_s),
      .data_i  (push_word_s),
      .pop_i   (pop_s),
      .data_o  (instr_o),
      .valid_o (instr_valid_o),
      .count_o (count_s),
      .full_o  (full_s)
   );

endmodule

// File: doc/zeroriscy_instr_encoder.md
# zeroriscy_instr_encoder

Command-driven RV32IM + RV32Xbnn instruction encoder: the encode direction of the core's decode/trace instruction masks. Accepts field-level commands (class, funct3, alt, rd, rs1, rs2, imm) over valid/ready and assembles legal 32-bit instruction words. Words are buffered in an output FIFO for a debug/test instruction-injection port in front of the fetch stage. Expands the LI pseudo-op into LUI/ADDI sequences.

## Interface
- FIFO_DEPTH, 4: output FIFO entries, power of two, ≥2.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous clear of FIFO and FSM.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_class_i  in  4  LUI=0, AUIPC=1, JAL=2, JALR=3, BRANCH=4, OPIMM=5, OP=6, MULDIV=7, CSR=8, SYS=9, BNN=10, LI=11; 12–15 illegal.
- cmd_funct3_i  in  3  funct3 (SYS: 0 ECALL, 1 EBREAK, 2 MRET, 3 WFI).
- cmd_alt_i  in  1  selects funct7=0100000 (SUB/SRA/SRAI).
- cmd_rd_i, cmd_rs1_i, cmd_rs2_i  in  5 each  register indices.
- cmd_imm_i  in  32  immediate, low bits used per format; BNN: imm[6:0] → funct7.
- instr_valid_o  out  1  FIFO head valid.
- instr_o  out  32  FIFO head word.
- instr_ready_i  in  1  consumer pops head when valid&ready.
- err_o  out  1  one-cycle pulse: illegal command consumed.
- count_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- FSM states: IDLE, LI_LO.
- IDLE: cmd_ready_o = !full. On accept, encode per class, push one word (or none if illegal).
- Formats: U (LUI/AUIPC, imm[31:12]); J (JAL, imm[20:1]); I (JALR funct3=000, OPIMM, CSR with imm[11:0] as csr); B (imm[12:1]); R (OP, MULDIV funct7=0000001); SYS fixed words 0x00000073/0x00100073/0x30200073/0x10500073; BNN R-type on OPCODE_BNN.
- Illegal → err_o, no push: class ≥12; BRANCH funct3 011; CSR funct3 000 or 100; SYS funct3 ≥4; alt set except OP funct3 000/101 or OPIMM funct3 101; JALR funct3≠000. Illegal command still consumes handshake.
- OPIMM shifts: imm[4:0] shamt, imm[11:5] replaced by alt-selected funct7.
- LI: if imm sign-fits 12 bits → ADDI rd,x0,imm. Else hi = (imm+0x800)>>12 (32-bit wrap); push LUI rd,hi; if imm[11:0]≠0 enter LI_LO, latch rd and imm[11:0]. rd=0 handled identically (words still emitted).
- LI_LO: cmd_ready_o=0; push ADDI rd,rd,lo when !full, return IDLE.
- FIFO: push and pop same cycle legal; no push when full (guaranteed by ready/FSM gating).
- flush_i: FIFO empty, FSM→IDLE, cmd_ready_o low that cycle, err_o 0; takes priority over push/pop.

## Timing
- Reset: cmd_ready_o 0 during reset, 1 first cycle after deassertion; instr_valid_o 0, instr_o 0, err_o 0, count_o 0, state IDLE.
- Accept at cycle N → word at FIFO head, instr_valid_o high at N+1 (FIFO empty case).
- LI two-word: LUI visible N+1, ADDI visible N+2 (not full); next command accepted N+2 earliest.
- err_o asserted cycle N+1 after illegal accept, one cycle.
- cmd_ready_o registered-only; no combinational path cmd_valid_i→cmd_ready_o or instr_ready_i→cmd_ready_o.
- Full with pop in same cycle: cmd_ready_o stays 0 that cycle (derived from registered count).
- Reset mid-LI: sequence abandoned, latched lo discarded.

## Structure
- Shared package zeroriscy_defines: opcode constants (already present), new cmd class enum, SYS fixed words, funct7 constants.
- Sub-module zeroriscy_instr_fifo (depth-parameterized, count output, flush); encoder FSM and combinational format logic in top.

## Test plan
- ADD x3,x1,x2 (class 6, f3 0) → 0x002081B3; SUB (alt=1) → 0x402081B3.
- LI x5,0x12345678 → 0x123452B7 then 0x67828293; LI x5,0x00001000 → only 0x000012B7; LI x5,-1 → 0xFFF00293.
- BEQ x1,x2,imm=-4 → 0xFE208EE3; BRANCH funct3 011 → err_o pulse, count_o unchanged.
- Stall instr_ready_i=0, push 4 commands → count_o=4, cmd_ready_o=0; release → 4 words in order, cmd_ready_o returns.
- LI mid-sequence with FIFO full → ADDI held until pop; flush_i during LI_LO → FIFO empty, IDLE.
- rst_n low asynchronously mid-stream → all outputs at reset values same cycle; MRET/WFI afterwards → 0x30200073, 0x10500073.
